// File: rtl/uart_tx_packer_pkg.sv
// Framing constants, pending-register type and small helpers for uart_tx_packer.
// Header byte values are shared with the decoder in uart_controller.
package uart_tx_packer_pkg;

    typedef enum logic [7:0] {
        HDR_ADS     = 8'hAA,
        HDR_MPR     = 8'hBB,
        HDR_REG_ADS = 8'h61,
        HDR_REG_MPR = 8'h6D,
        HDR_R       = 8'h52,
        HDR_S       = 8'h53
    } hdr_e;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_REG,
        SRC_ADS,
        SRC_MPR
    } src_e;

    typedef struct packed {
        logic  valid;
        word_t word;
    } pend_t;

    function automatic word_t frame_ads(input logic [23:0] data);
        return {HDR_ADS, data};
    endfunction

    function automatic word_t frame_mpr(input logic [15:0] data);
        return {HDR_MPR, data, 8'h00};
    endfunction

    function automatic word_t frame_reg(input logic       src,
                                        input logic [7:0] addr,
                                        input logic [7:0] data);
        hdr_e hdr;
        hdr = src ? HDR_REG_MPR : HDR_REG_ADS;
        return {hdr, addr, data, 8'h00};
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] cnt,
                                            input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/uart_tx_packer_sync_fifo.sv
// Single-clock FIFO with show-ahead read data and an occupancy count.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_fire;
    logic             rd_fire;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign wr_fire   = wr_en_i & ~full_o;
    assign rd_fire   = rd_en_i & ~empty_o;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_packer.sv
// Frames ADS samples, MPR touch words and register replies into 32-bit words, queues them
// and presents them to uart_controller using its drop-READY-after-latch handshake.
module uart_tx_packer
    import uart_tx_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    input  logic [23:0]        i_ADS_DATA,
    input  logic               i_ADS_VALID,
    input  logic [15:0]        i_MPR_DATA,
    input  logic               i_MPR_VALID,
    input  logic               i_REG_SRC,
    input  logic [7:0]         i_REG_ADDR,
    input  logic [7:0]         i_REG_DATA,
    input  logic               i_REG_VALID,
    output logic [31:0]        o_TX_DATA,
    output logic               o_TX_VALID,
    input  logic               i_TX_READY,
    output logic [FIFO_AW:0]   o_FIFO_LEVEL,
    output logic [7:0]         o_DROP_CNT
);

    pend_t            reg_q, reg_d;
    pend_t            ads_q, ads_d;
    pend_t            mpr_q, mpr_d;
    src_e             grant;
    logic             fifo_wr, fifo_rd, fifo_full, fifo_empty;
    word_t            fifo_wdata, fifo_rdata;
    logic [FIFO_AW:0] fifo_count;
    logic             tx_valid_q, tx_valid_d;
    word_t            tx_data_q, tx_data_d;
    logic             ready_d1_q;
    logic             accept;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             drop_reg, drop_ads, drop_mpr;

    // A grant frees the slot on the same edge, so a simultaneous pulse is loaded, not dropped.
    function automatic pend_t pend_next(input pend_t cur, input logic granted,
                                        input logic pulse, input word_t word);
        pend_t nxt;
        nxt = cur;
        if (granted) nxt.valid = 1'b0;
        if (pulse && !nxt.valid) begin
            nxt.valid = 1'b1;
            nxt.word  = word;
        end
        return nxt;
    endfunction

    always_comb begin
        grant = SRC_NONE;
        if (!fifo_full) begin
            if (reg_q.valid)      grant = SRC_REG;
            else if (ads_q.valid) grant = SRC_ADS;
            else if (mpr_q.valid) grant = SRC_MPR;
        end
    end

    always_comb begin
        fifo_wdata = '0;
        case (grant)
            SRC_REG: fifo_wdata = reg_q.word;
            SRC_ADS: fifo_wdata = ads_q.word;
            SRC_MPR: fifo_wdata = mpr_q.word;
            default: fifo_wdata = '0;
        endcase
    end

    assign fifo_wr = (grant != SRC_NONE);

    always_comb begin
        reg_d = pend_next(reg_q, grant == SRC_REG, i_REG_VALID,
                          frame_reg(i_REG_SRC, i_REG_ADDR, i_REG_DATA));
        ads_d = pend_next(ads_q, grant == SRC_ADS, i_ADS_VALID, frame_ads(i_ADS_DATA));
        mpr_d = pend_next(mpr_q, grant == SRC_MPR, i_MPR_VALID, frame_mpr(i_MPR_DATA));
    end

    assign drop_reg   = i_REG_VALID & reg_q.valid & (grant != SRC_REG);
    assign drop_ads   = i_ADS_VALID & ads_q.valid & (grant != SRC_ADS);
    assign drop_mpr   = i_MPR_VALID & mpr_q.valid & (grant != SRC_MPR);
    assign drop_cnt_d = sat_add8(drop_cnt_q, 2'(drop_reg) + 2'(drop_ads) + 2'(drop_mpr));

    // The controller latches on the cycle READY falls; READY high alone is not a transfer.
    assign accept  = tx_valid_q & ready_d1_q & ~i_TX_READY;
    assign fifo_rd = ~tx_valid_q & ~fifo_empty;

    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (accept) begin
            tx_valid_d = 1'b0;
        end else if (fifo_rd) begin
            tx_valid_d = 1'b1;
            tx_data_d  = fifo_rdata;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk_i     (i_CLK),
        .rst_i     (i_RST),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            reg_q      <= '0;
            ads_q      <= '0;
            mpr_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            ready_d1_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            reg_q      <= reg_d;
            ads_q      <= ads_d;
            mpr_q      <= mpr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            ready_d1_q <= i_TX_READY;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_TX_DATA    = tx_data_q;
    assign o_TX_VALID   = tx_valid_q;
    assign o_FIFO_LEVEL = fifo_count + (FIFO_AW+1)'(tx_valid_q);
    assign o_DROP_CNT   = drop_cnt_q;

endmodule

// File: tb/tb_uart_tx_packer.sv
// Directed bench for uart_tx_packer: stimulus pushes expected words, a monitor pops them
// whenever the controller-side handshake completes a transfer.
module tb_uart_tx_packer;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic [23:0] ads_data  = '0;
    logic        ads_valid = 1'b0;
    logic [15:0] mpr_data  = '0;
    logic        mpr_valid = 1'b0;
    logic        reg_src   = 1'b0;
    logic [7:0]  reg_addr  = '0;
    logic [7:0]  reg_data  = '0;
    logic        reg_valid = 1'b0;
    logic        tx_ready  = 1'b0;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic [4:0]  level;
    logic [7:0]  drop_cnt;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    logic        mon_prev_ready = 1'b0;
    logic        mon_prev_valid = 1'b0;
    logic [31:0] mon_prev_data  = '0;

    always #5 clk = ~clk;

    uart_tx_packer #(
        .FIFO_DEPTH (16),
        .FIFO_AW    (4)
    ) dut (
        .i_CLK        (clk),
        .i_RST        (rst),
        .i_ADS_DATA   (ads_data),
        .i_ADS_VALID  (ads_valid),
        .i_MPR_DATA   (mpr_data),
        .i_MPR_VALID  (mpr_valid),
        .i_REG_SRC    (reg_src),
        .i_REG_ADDR   (reg_addr),
        .i_REG_DATA   (reg_data),
        .i_REG_VALID  (reg_valid),
        .o_TX_DATA    (tx_data),
        .o_TX_VALID   (tx_valid),
        .i_TX_READY   (tx_ready),
        .o_FIFO_LEVEL (level),
        .o_DROP_CNT   (drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a transfer is VALID with READY high last cycle and low now.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                mon_prev_ready = 1'b0;
                mon_prev_valid = 1'b0;
            end else begin
                if (mon_prev_valid && tx_valid)
                    check("data_stable", tx_data, mon_prev_data);
                if (tx_valid && mon_prev_ready && !tx_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word: got %h expected none", tx_data);
                    end else begin
                        check("tx_word", tx_data, exp_q.pop_front());
                    end
                end
                mon_prev_ready = tx_ready;
                mon_prev_valid = tx_valid;
                mon_prev_data  = tx_data;
            end
        end
    end

    task automatic pulse_ads(input logic [23:0] d);
        ads_data  = d;
        ads_valid = 1'b1;
        @(negedge clk);
        ads_valid = 1'b0;
    endtask

    task automatic pulse_mpr(input logic [15:0] d);
        mpr_data  = d;
        mpr_valid = 1'b1;
        @(negedge clk);
        mpr_valid = 1'b0;
    endtask

    task automatic pulse_reg(input logic src, input logic [7:0] a, input logic [7:0] d);
        reg_src   = src;
        reg_addr  = a;
        reg_data  = d;
        reg_valid = 1'b1;
        @(negedge clk);
        reg_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!tx_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(tx_valid), 32'd1);
    endtask

    // Raise READY for one cycle and drop it so the controller-side latch occurs.
    task automatic pop_one();
        wait_valid("pop_wait", 20);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data",  tx_data,       32'd0);
        check("rst_level", 32'(level),    32'd0);
        check("rst_drop",  32'(drop_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single ADS word with READY parked high: held until READY falls.
        tx_ready = 1'b1;
        exp_q.push_back(32'hAA123456);
        pulse_ads(24'h123456);
        check("ads_lat_c1", 32'(tx_valid), 32'd0);
        @(negedge clk);
        check("ads_lat_c2", 32'(tx_valid), 32'd0);
        @(negedge clk);
        check("ads_lat_c3", 32'(tx_valid), 32'd1);
        check("ads_data",   tx_data,       32'hAA123456);
        check("ads_level",  32'(level),    32'd1);
        repeat (5) @(negedge clk);
        check("ads_hold",   32'(tx_valid), 32'd1);
        tx_ready = 1'b0;
        @(negedge clk);
        check("ads_popped", 32'(tx_valid), 32'd0);
        check("ads_level0", 32'(level),    32'd0);

        // All three sources in one cycle: REG > ADS > MPR.
        exp_q.push_back(32'h6D5D2400);
        exp_q.push_back(32'hAA000001);
        exp_q.push_back(32'hBBBEEF00);
        ads_data  = 24'h000001; ads_valid = 1'b1;
        mpr_data  = 16'hBEEF;   mpr_valid = 1'b1;
        reg_src   = 1'b1; reg_addr = 8'h5D; reg_data = 8'h24; reg_valid = 1'b1;
        @(negedge clk);
        ads_valid = 1'b0; mpr_valid = 1'b0; reg_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("prio_level", 32'(level),    32'd3);
        check("prio_head",  tx_data,       32'h6D5D2400);
        check("prio_drop",  32'(drop_cnt), 32'd0);
        repeat (3) pop_one();
        check("prio_empty", 32'(level),    32'd0);

        // ADS register reply framing.
        exp_q.push_back(32'h61112200);
        pulse_reg(1'b0, 8'h11, 8'h22);
        pop_one();

        // Back-to-back ADS pulses: capture and grant on the same edge, nothing dropped.
        exp_q.push_back(32'hAA111111);
        exp_q.push_back(32'hAA222222);
        exp_q.push_back(32'hAA333333);
        ads_valid = 1'b1;
        ads_data = 24'h111111; @(negedge clk);
        ads_data = 24'h222222; @(negedge clk);
        ads_data = 24'h333333; @(negedge clk);
        ads_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_drop",  32'(drop_cnt), 32'd0);
        check("b2b_level", 32'(level),    32'd3);
        repeat (3) pop_one();

        // READY high forever is never a transfer.
        tx_ready = 1'b1;
        exp_q.push_back(32'hAA00ABCD);
        pulse_ads(24'h00ABCD);
        wait_valid("noack_valid", 10);
        repeat (50) @(negedge clk);
        check("noack_level", 32'(level),    32'd1);
        check("noack_valid", 32'(tx_valid), 32'd1);
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("noack_done",  32'(level),    32'd0);

        // Fill: 1 output + 16 FIFO + 1 pending, last two pulses dropped.
        for (int i = 0; i < 20; i++) begin
            if (i < 18) exp_q.push_back({8'hAA, 24'(24'h000100 + i)});
            pulse_ads(24'(24'h000100 + i));
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("fill_level", 32'(level),    32'd17);
        check("fill_drop",  32'(drop_cnt), 32'd2);
        check("fill_head",  tx_data,       32'hAA000100);

        // MPR floods a full FIFO: first pulse is held pending, the rest drop until saturation.
        exp_q.push_back(32'hBB0F0F00);
        for (int i = 0; i < 300; i++) begin
            pulse_mpr(16'h0F0F);
            @(negedge clk);
            if (i == 99)  check("sat_drop_100", 32'(drop_cnt), 32'd101);
            if (i == 252) check("sat_drop_254", 32'(drop_cnt), 32'd254);
        end
        check("sat_drop",  32'(drop_cnt), 32'd255);
        check("sat_level", 32'(level),    32'd17);

        // Asynchronous reset mid-cycle with content queued.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(tx_valid), 32'd0);
        check("arst_level", 32'(level),    32'd0);
        check("arst_drop",  32'(drop_cnt), 32'd0);
        check("arst_data",  tx_data,       32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_level", 32'(level), 32'd0);
        exp_q.push_back(32'hAAC0FFEE);
        pulse_ads(24'hC0FFEE);
        pop_one();
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_level",   32'(level),        32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
